// File: rtl/aibcr3_sigbuf_seq.sv
// ---------------------------------------------------------------------------
// aibcr3_sigbuf_seq
//
// Staggered enable/disable sequencer for the AIB signal-buffer groups of the
// aibcr3 IO column. It turns buffer groups on one at a time, from group 0
// upward, with a programmable gap between steps. This limits inrush current
// and simultaneous-switching noise. On power-down it releases the groups in
// reverse order with the same gap.
//
// Ports
//   clk        in   1        sequencer clock
//   reset      in   1        asynchronous, active-high reset
//   seq_req    in   1        level request: 1 = groups on, 0 = groups off
//   dly_cfg    in   DLY_W    step delay; adjacent events are dly_cfg+1 apart
//   grp_en     out  NUM_GRP  buffer-group enables, thermometer-coded from bit 0
//   seq_busy   out  1        sequence in progress (UP or DOWN)
//   seq_done   out  1        all groups on and settled (ON)
//   dbg_state  out  2        current FSM state encoding, for observation
//
// Handshake: seq_req is a plain level, not a valid/ready pair. The block
// follows whatever level it samples on each edge. A change of level reverses
// the sequence on that same edge.
// ---------------------------------------------------------------------------
module aibcr3_sigbuf_seq #(
    parameter int NUM_GRP = 4,
    parameter int DLY_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               seq_req,
    input  logic [DLY_W-1:0]   dly_cfg,
    output logic [NUM_GRP-1:0] grp_en,
    output logic               seq_busy,
    output logic               seq_done,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [DLY_W-1:0]   cnt;
    logic [DLY_W-1:0]   next_cnt;
    logic [NUM_GRP-1:0] next_grp_en;

    // grp_en is always thermometer-coded. Setting the next bit is therefore a
    // shift-in of a one. Clearing the highest set bit is a logical right shift.
    // Each operation changes exactly one bit.
    logic [NUM_GRP-1:0] grp_set;
    logic [NUM_GRP-1:0] grp_clr;
    logic [DLY_W-1:0]   cnt_dec;
    logic               grp_all;
    logic               grp_none;

    assign grp_set  = {grp_en[NUM_GRP-2:0], 1'b1};
    assign grp_clr  = grp_en >> 1;
    assign grp_all  = &grp_en;
    assign grp_none = ~|grp_en;
    assign cnt_dec  = (cnt == '0) ? '0 : cnt - 1'b1;

    // Next-state and next-output logic. Each arm that changes grp_en or
    // enters a new state reloads cnt from dly_cfg. dly_cfg is sampled only
    // here, so a change made mid-step takes effect at the next load.
    always_comb begin
        next_state  = state;
        next_grp_en = grp_en;
        next_cnt    = cnt;
        unique case (state)
            ST_IDLE: begin
                next_grp_en = '0;
                if (seq_req) begin
                    next_state  = ST_UP;
                    next_grp_en = {{(NUM_GRP-1){1'b0}}, 1'b1};
                    next_cnt    = dly_cfg;
                end
            end
            ST_UP: begin
                if (!seq_req) begin
                    // Reversal never waits for the current gap to expire.
                    next_state  = ST_DOWN;
                    next_grp_en = grp_clr;
                    next_cnt    = dly_cfg;
                end else if (cnt != '0) begin
                    next_cnt = cnt_dec;
                end else if (!grp_all) begin
                    next_grp_en = grp_set;
                    next_cnt    = dly_cfg;
                end else begin
                    // The last group gets a full gap to settle before done.
                    next_state = ST_ON;
                    next_cnt   = dly_cfg;
                end
            end
            ST_ON: begin
                if (!seq_req) begin
                    next_state  = ST_DOWN;
                    next_grp_en = grp_clr;
                    next_cnt    = dly_cfg;
                end
            end
            ST_DOWN: begin
                if (seq_req) begin
                    next_state  = ST_UP;
                    next_grp_en = grp_set;
                    next_cnt    = dly_cfg;
                end else if (cnt != '0) begin
                    next_cnt = cnt_dec;
                end else if (!grp_none) begin
                    next_grp_en = grp_clr;
                    next_cnt    = dly_cfg;
                end else begin
                    next_state = ST_IDLE;
                    next_cnt   = dly_cfg;
                end
            end
            default: begin
                next_state  = ST_IDLE;
                next_grp_en = '0;
                next_cnt    = '0;
            end
        endcase
    end

    // State and registered outputs. The status flags are decoded from
    // next_state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            grp_en   <= '0;
            cnt      <= '0;
            seq_busy <= 1'b0;
            seq_done <= 1'b0;
        end else begin
            state    <= next_state;
            grp_en   <= next_grp_en;
            cnt      <= next_cnt;
            seq_busy <= (next_state == ST_UP) || (next_state == ST_DOWN);
            seq_done <= (next_state == ST_ON);
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_aibcr3_sigbuf_seq.sv
module tb_aibcr3_sigbuf_seq;

    localparam int NUM_GRP = 4;
    localparam int DLY_W   = 8;

    // Reference-model modes (independent of the DUT encoding).
    localparam int M_OFF  = 0;
    localparam int M_RISE = 1;
    localparam int M_FULL = 2;
    localparam int M_FALL = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               seq_req;
    logic [DLY_W-1:0]   dly_cfg;
    logic [NUM_GRP-1:0] grp_en;
    logic               seq_busy;
    logic               seq_done;
    logic [1:0]         dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: number of groups on, remaining gap cycles, mode.
    int m_mode;
    int m_level;
    int m_wait;
    logic [NUM_GRP-1:0] prev_grp;

    aibcr3_sigbuf_seq #(.NUM_GRP(NUM_GRP), .DLY_W(DLY_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .seq_req   (seq_req),
        .dly_cfg   (dly_cfg),
        .grp_en    (grp_en),
        .seq_busy  (seq_busy),
        .seq_done  (seq_done),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_OFF;
        m_level = 0;
        m_wait  = 0;
    endtask

    // One clock edge of the behavioural model, using the current inputs.
    task automatic model_edge();
        int d;
        d = int'(dly_cfg);
        case (m_mode)
            M_OFF: if (seq_req) begin m_mode = M_RISE; m_level = 1; m_wait = d; end
            M_RISE: begin
                if (!seq_req) begin m_mode = M_FALL; m_level--; m_wait = d; end
                else if (m_wait > 0) m_wait--;
                else if (m_level < NUM_GRP) begin m_level++; m_wait = d; end
                else begin m_mode = M_FULL; m_wait = d; end
            end
            M_FULL: if (!seq_req) begin m_mode = M_FALL; m_level = NUM_GRP - 1; m_wait = d; end
            default: begin
                if (seq_req) begin m_mode = M_RISE; m_level++; m_wait = d; end
                else if (m_wait > 0) m_wait--;
                else if (m_level > 0) begin m_level--; m_wait = d; end
                else begin m_mode = M_OFF; m_wait = d; end
            end
        endcase
    endtask

    // Advance one edge, then compare against the model and the invariants.
    task automatic step();
        logic [31:0] exp_grp;
        model_edge();
        @(posedge clk);
        #1;
        exp_grp = (32'd1 << m_level) - 32'd1;
        chk("grp_en", 32'(grp_en), exp_grp);
        chk("seq_busy", 32'(seq_busy), 32'((m_mode == M_RISE) || (m_mode == M_FALL)));
        chk("seq_done", 32'(seq_done), 32'(m_mode == M_FULL));
        chk("thermometer", 32'(((grp_en + 1'b1) & grp_en) == '0), 32'd1);
        chk("one_bit_step", 32'($countones(grp_en ^ prev_grp) <= 1), 32'd1);
        chk("busy_done_excl", 32'(seq_busy & seq_done), 32'd0);
        prev_grp = grp_en;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [3:0] tz_up [5];
        logic [3:0] tz_dn [5];
        tz_up = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};
        tz_dn = '{4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b0000};

        // Reset
        reset   = 1'b1;
        seq_req = 1'b0;
        dly_cfg = '0;
        model_reset();
        prev_grp = '0;
        #12;
        chk("rst_grp_en", 32'(grp_en), 32'd0);
        chk("rst_busy", 32'(seq_busy), 32'd0);
        chk("rst_done", 32'(seq_done), 32'd0);
        reset = 1'b0;
        run(3);
        chk("idle_hold", 32'(grp_en), 32'd0);

        // Basic up/down, dly_cfg=2
        dly_cfg = 8'd2;
        seq_req = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            step();
            if (i == 0) chk("up_e0", 32'(grp_en), 32'h1);
            if (i == 0) chk("up_e0_busy", 32'(seq_busy), 32'd1);
            if (i == 3) chk("up_e3", 32'(grp_en), 32'h3);
            if (i == 6) chk("up_e6", 32'(grp_en), 32'h7);
            if (i == 9) chk("up_e9", 32'(grp_en), 32'hf);
            if (i == 11) chk("up_e11_done", 32'(seq_done), 32'd0);
            if (i == 12) chk("up_e12_done", 32'(seq_done), 32'd1);
            if (i == 12) chk("up_e12_busy", 32'(seq_busy), 32'd0);
        end
        seq_req = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            step();
            if (i == 0) chk("dn_e0", 32'(grp_en), 32'h7);
            if (i == 0) chk("dn_e0_done", 32'(seq_done), 32'd0);
            if (i == 3) chk("dn_e3", 32'(grp_en), 32'h3);
            if (i == 6) chk("dn_e6", 32'(grp_en), 32'h1);
            if (i == 9) chk("dn_e9", 32'(grp_en), 32'h0);
            if (i == 11) chk("dn_e11_busy", 32'(seq_busy), 32'd1);
            if (i == 12) chk("dn_e12_busy", 32'(seq_busy), 32'd0);
        end

        // Zero delay
        dly_cfg = 8'd0;
        seq_req = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            step();
            chk("zd_up", 32'(grp_en), 32'(tz_up[i]));
            if (i == 4) chk("zd_done", 32'(seq_done), 32'd1);
        end
        seq_req = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            step();
            chk("zd_dn", 32'(grp_en), 32'(tz_dn[i]));
            if (i == 4) chk("zd_idle_busy", 32'(seq_busy), 32'd0);
        end

        // Mid-sequence reversal, dly_cfg=3
        dly_cfg = 8'd3;
        seq_req = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            step();
            if (i == 4) chk("rev_up_e4", 32'(grp_en), 32'h3);
        end
        seq_req = 1'b0;
        step();
        chk("rev_drop", 32'(grp_en), 32'h1);
        chk("rev_drop_busy", 32'(seq_busy), 32'd1);
        for (int j = 1; j <= 4; j++) begin
            step();
            if (j == 3) chk("rev_hold", 32'(grp_en), 32'h1);
            if (j == 4) chk("rev_clear", 32'(grp_en), 32'h0);
        end
        seq_req = 1'b1;
        step();
        chk("rev_reraise", 32'(grp_en), 32'h1);
        run(20);
        seq_req = 1'b0;
        dly_cfg = 8'd0;
        run(6);

        // dly_cfg change mid-step: 5 -> 1 while cnt=3
        dly_cfg = 8'd5;
        seq_req = 1'b1;
        run(3);
        dly_cfg = 8'd1;
        for (int i = 3; i <= 12; i++) begin
            step();
            if (i == 5) chk("dc_e5", 32'(grp_en), 32'h1);
            if (i == 6) chk("dc_e6", 32'(grp_en), 32'h3);
            if (i == 7) chk("dc_e7", 32'(grp_en), 32'h3);
            if (i == 8) chk("dc_e8", 32'(grp_en), 32'h7);
            if (i == 10) chk("dc_e10", 32'(grp_en), 32'hf);
            if (i == 12) chk("dc_done", 32'(seq_done), 32'd1);
        end
        seq_req = 1'b0;
        dly_cfg = 8'd0;
        run(6);

        // Maximum delay: gap of 256 cycles
        dly_cfg = 8'd255;
        seq_req = 1'b1;
        for (int i = 0; i <= 256; i++) begin
            step();
            if (i == 255) chk("max_e255", 32'(grp_en), 32'h1);
            if (i == 256) chk("max_e256", 32'(grp_en), 32'h3);
        end
        seq_req = 1'b0;
        dly_cfg = 8'd0;
        run(6);

        // Async reset mid-UP with grp_en=0111
        dly_cfg = 8'd2;
        seq_req = 1'b1;
        run(7);
        chk("ar_pre", 32'(grp_en), 32'h7);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("ar_grp_en", 32'(grp_en), 32'd0);
        chk("ar_busy", 32'(seq_busy), 32'd0);
        chk("ar_done", 32'(seq_done), 32'd0);
        prev_grp = '0;
        #2;
        reset = 1'b0;
        step();
        chk("ar_restart", 32'(grp_en), 32'h1);
        run(14);

        // Randomized seq_req / dly_cfg against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) seq_req = ~seq_req;
            if ($urandom_range(0, 3) == 0) dly_cfg = DLY_W'($urandom_range(0, 3));
            step();
        end
        // Toggle every cycle
        for (int i = 0; i < 20; i++) begin
            seq_req = ~seq_req;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
